// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the cache slice.
// Fetch-side word type, default geometry and icache FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS = 16;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache.
// Zero-cycle hits, single-word fill on miss, fill bypass to fetch.
module icache
  import cpu_types_pkg::*;
#(
  parameter  int SETS  = ICACHE_SETS,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    word_t            data;
  } icache_frame_t;

  icache_state_t    state;
  word_t            miss_addr;
  logic [SETS-1:0]  valid;
  icache_frame_t    frames [SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] m_idx;
  logic [TAG_W-1:0] m_tag;
  logic             hit;
  logic             fill;
  logic             bypass;

  assign idx   = imemaddr[IDX_W+1:2];
  assign tag   = imemaddr[31:IDX_W+2];
  assign m_idx = miss_addr[IDX_W+1:2];
  assign m_tag = miss_addr[31:IDX_W+2];

  assign hit = imemREN && valid[idx]
            && (frames[idx].tag == tag);

  assign fill   = (state == FETCH) && !iwait;
  assign bypass = fill && imemREN
               && (imemaddr == miss_addr);

  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          ihit     = 1'b1;
          imemload = frames[idx].data;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        if (bypass) begin
          ihit     = 1'b1;
          imemload = iload;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
      valid     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (imemREN && !hit) begin
            miss_addr <= imemaddr;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (!iwait) begin
            valid[m_idx] <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data need no reset; valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (fill) begin
      frames[m_idx].tag  <= m_tag;
      frames[m_idx].data <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache.
// Stimulus queues per-cycle expectations; a monitor pops and compares.
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  icache dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    logic        eh;
    logic [31:0] el;
    logic        er;
    logic [31:0] ea;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   sid    = 0;

  task automatic chk(input string name, input int id,
                     input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s step %0d got %h want %h",
               name, id, act, want);
    end
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ihit",     e.id, {31'b0, ihit}, {31'b0, e.eh});
      chk("imemload", e.id, imemload,      e.el);
      chk("iREN",     e.id, {31'b0, iREN}, {31'b0, e.er});
      chk("iaddr",    e.id, iaddr,         e.ea);
    end
  end

  task automatic step(input logic rst, input logic ren,
                      input logic [31:0] addr,
                      input logic w, input logic [31:0] ld,
                      input logic eh, input logic [31:0] el,
                      input logic er, input logic [31:0] ea);
    nRST     = rst;
    imemREN  = ren;
    imemaddr = addr;
    iwait    = w;
    iload    = ld;
    sid++;
    q.push_back('{sid, eh, el, er, ea});
    @(posedge CLK);
    #1;
  endtask

  // Miss in IDLE then immediate fill with bypass hit.
  task automatic miss_fill(input logic [31:0] a,
                           input logic [31:0] d);
    step(1, 1, a, 1, 0, 0, 0, 0, 0);
    step(1, 1, a, 0, d, 1, d, 1, a);
  endtask

  task automatic hit_chk(input logic [31:0] a,
                         input logic [31:0] d);
    step(1, 1, a, 1, 0, 1, d, 0, 0);
  endtask

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    iwait    = 1'b1;
    iload    = '0;
    @(posedge CLK);
    #1;

    // reset state
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h10, 1, 0, 0, 0, 0, 0);

    // first miss with 3 wait cycles
    step(1, 1, 32'h10, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 1, 32'h10, 1, 32'hFFFF_FFFF,
           0, 0, 1, 32'h10);
    step(1, 1, 32'h10, 0, 32'h3C01_0004,
         1, 32'h3C01_0004, 1, 32'h10);
    hit_chk(32'h10, 32'h3C01_0004);
    step(1, 0, 32'h10, 1, 0, 0, 0, 0, 0);

    // conflict on idx 4
    miss_fill(32'h50, 32'hDEAD_BEEF);
    hit_chk(32'h50, 32'hDEAD_BEEF);
    miss_fill(32'h10, 32'h3C01_0004);
    hit_chk(32'h10, 32'h3C01_0004);

    // redirect mid-fill
    step(1, 1, 32'h20, 1, 0, 0, 0, 0, 0);
    step(1, 1, 32'h20, 1, 0, 0, 0, 1, 32'h20);
    step(1, 1, 32'h80, 1, 0, 0, 0, 1, 32'h20);
    step(1, 1, 32'h80, 0, 32'h1111_2222,
         0, 0, 1, 32'h20);
    miss_fill(32'h80, 32'h8080_8080);
    hit_chk(32'h20, 32'h1111_2222);
    hit_chk(32'h80, 32'h8080_8080);

    // imemREN dropped during fill
    step(1, 1, 32'h30, 1, 0, 0, 0, 0, 0);
    step(1, 0, 32'h30, 1, 0, 0, 0, 1, 32'h30);
    step(1, 0, 32'h30, 0, 32'h3030_3030,
         0, 0, 1, 32'h30);
    step(1, 0, 32'h30, 1, 0, 0, 0, 0, 0);
    hit_chk(32'h30, 32'h3030_3030);

    // reset asserted mid-fill
    step(1, 1, 32'h40, 1, 0, 0, 0, 0, 0);
    step(1, 1, 32'h40, 1, 0, 0, 0, 1, 32'h40);
    step(0, 1, 32'h40, 1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h40, 0, 32'h4444_4444,
         0, 0, 0, 0);
    step(1, 1, 32'h30, 1, 0, 0, 0, 0, 0);
    step(1, 1, 32'h30, 1, 0, 0, 0, 1, 32'h30);
    step(1, 1, 32'h10, 0, 32'h3030_3031,
         0, 0, 1, 32'h30);
    miss_fill(32'h10, 32'h3C01_0004);

    // fill every set, then 16 back-to-back hits
    for (int i = 0; i < 16; i++) begin
      if (i == 4)
        hit_chk(32'h10, 32'h3C01_0004);
      else if (i == 12)
        hit_chk(32'h30, 32'h3030_3031);
      else
        miss_fill(i * 4, 32'hA500_0000 | i);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 4)
        hit_chk(32'h10, 32'h3C01_0004);
      else if (i == 12)
        hit_chk(32'h30, 32'h3030_3031);
      else
        hit_chk(i * 4, 32'hA500_0000 | i);
    end
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 5 && q.size() > 0; i++)
      @(negedge CLK);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
